// File: rtl/ttt_str_to_grid.sv
// rtl/ttt_str_to_grid.sv - rebuilds the 9-cell tic-tac-toe grid from a serial ASCII board string
// Optional X/O count legality check enabled by defining TTT_COUNT_CHECK_EN.
module ttt_str_to_grid #(
    parameter logic [7:0] SYNC_CHAR = 8'h0A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [8:0] grid_state_marked,
    output logic [8:0] grid_state_x,
    output logic       grid_valid,
    output logic       frame_error,
    output logic [3:0] cell_count
);

    typedef enum logic [1:0] {COLLECT, DONE, ERR} state_t;

    state_t     state, state_nx;
    logic [3:0] count_nx;
    logic [8:0] shadow_marked, shadow_x, sm_nx, sx_nx, gm_nx, gx_nx;
    logic       fe_nx;
    logic       accept, is_x, is_o, is_cell, is_eol, legal;
    logic [8:0] onehot, full_m, full_x;

    assign accept  = in_valid && in_ready;
    assign is_x    = (in_data == 8'h78);
    assign is_o    = (in_data == 8'h6F);
    assign is_cell = is_x || is_o || (in_data == 8'h5F);
    assign is_eol  = (in_data == SYNC_CHAR) || (in_data == 8'h0D);

    // First character of a frame lands in cell 8, the ninth in cell 0.
    assign onehot = 9'(1) << (4'd8 - cell_count);
    assign full_m = (shadow_marked & ~onehot) | ((is_x || is_o) ? onehot : 9'd0);
    assign full_x = (shadow_x & ~onehot) | (is_x ? onehot : 9'd0);

`ifdef TTT_COUNT_CHECK_EN
    logic [3:0] cnt_x, cnt_o;
    always_comb begin
        cnt_x = '0;
        cnt_o = '0;
        for (int i = 0; i < 9; i++) begin
            cnt_x = cnt_x + {3'b000, full_m[i] & full_x[i]};
            cnt_o = cnt_o + {3'b000, full_m[i] & ~full_x[i]};
        end
    end
    // X always moves first, so X leads O by zero or one.
    assign legal = (cnt_x == cnt_o) || (cnt_x == cnt_o + 4'd1);
`else
    assign legal = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        count_nx = cell_count;
        sm_nx    = shadow_marked;
        sx_nx    = shadow_x;
        gm_nx    = grid_state_marked;
        gx_nx    = grid_state_x;
        fe_nx    = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    if (is_cell) begin
                        sm_nx = full_m;
                        sx_nx = full_x;
                        if (cell_count == 4'd8) begin
                            count_nx = 4'd0;
                            if (legal) begin
                                gm_nx    = full_m;
                                gx_nx    = full_x;
                                state_nx = DONE;
                            end else begin
                                fe_nx    = 1'b1;
                                state_nx = ERR;
                            end
                        end else begin
                            count_nx = cell_count + 4'd1;
                        end
                    end else if (!(is_eol && cell_count == 4'd0)) begin
                        fe_nx    = 1'b1;
                        count_nx = 4'd0;
                        state_nx = ERR;
                    end
                end
            end
            DONE:    state_nx = COLLECT;
            ERR: begin
                if (accept && in_data == SYNC_CHAR)
                    state_nx = COLLECT;
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= COLLECT;
            cell_count        <= 4'd0;
            shadow_marked     <= 9'd0;
            shadow_x          <= 9'd0;
            grid_state_marked <= 9'd0;
            grid_state_x      <= 9'd0;
            frame_error       <= 1'b0;
        end else begin
            state             <= state_nx;
            cell_count        <= count_nx;
            shadow_marked     <= sm_nx;
            shadow_x          <= sx_nx;
            grid_state_marked <= gm_nx;
            grid_state_x      <= gx_nx;
            frame_error       <= fe_nx;
        end
    end

    assign in_ready   = (state != DONE);
    assign grid_valid = (state == DONE);

endmodule

// File: tb/tb_ttt_str_to_grid.sv
// tb/tb_ttt_str_to_grid.sv - self-checking bench for ttt_str_to_grid
module tb_ttt_str_to_grid;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] grid_state_marked;
    logic [8:0] grid_state_x;
    logic       grid_valid;
    logic       frame_error;
    logic [3:0] cell_count;

    int ncmp = 0;
    int nfail = 0;

    // reference model: pending frame characters and error mode
    logic [7:0] mq[$];
    bit         merr;
    logic [8:0] egm, egx;
    bit         egv, efe;

    ttt_str_to_grid dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .grid_state_marked(grid_state_marked),
        .grid_state_x     (grid_state_x),
        .grid_valid       (grid_valid),
        .frame_error      (frame_error),
        .cell_count       (cell_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        merr = 0;
        egm = 9'd0;
        egx = 9'd0;
        egv = 0;
        efe = 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        int nx, no;
        bit ok;
        egv = 0;
        efe = 0;
        if (merr) begin
            if (b == 8'h0A) merr = 0;
        end else if (b == 8'h78 || b == 8'h6F || b == 8'h5F) begin
            mq.push_back(b);
            if (mq.size() == 9) begin
                nx = 0;
                no = 0;
                foreach (mq[i]) begin
                    if (mq[i] == 8'h78) nx++;
                    if (mq[i] == 8'h6F) no++;
                end
                ok = 1;
`ifdef TTT_COUNT_CHECK_EN
                ok = (nx == no) || (nx == no + 1);
`endif
                if (ok) begin
                    for (int i = 0; i < 9; i++) begin
                        egm[8 - i] = (mq[i] != 8'h5F);
                        egx[8 - i] = (mq[i] == 8'h78);
                    end
                    egv = 1;
                end else begin
                    efe = 1;
                    merr = 1;
                end
                mq.delete();
            end
        end else if ((b == 8'h0A || b == 8'h0D) && mq.size() == 0) begin
            // blank line between frames
        end else begin
            efe = 1;
            merr = 1;
            mq.delete();
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".grid_valid"}, 9'(grid_valid), 9'(egv));
        chk({tag, ".frame_error"}, 9'(frame_error), 9'(efe));
        chk({tag, ".in_ready"}, 9'(in_ready), 9'(!egv));
        chk({tag, ".marked"}, grid_state_marked, egm);
        chk({tag, ".x"}, grid_state_x, egx);
        chk({tag, ".cell_count"}, 9'(cell_count), 9'(mq.size()));
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", 9'(in_ready), 9'd1);
            return;
        end
        @(posedge clk);
        #1;
        model_accept(b);
        check_all("byte");
        if (egv) begin
            @(posedge clk);
            #1;
            egv = 0;
            chk("pulse_end.grid_valid", 9'(grid_valid), 9'd0);
            chk("pulse_end.in_ready", 9'(in_ready), 9'd1);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            egv = 0;
            efe = 0;
            check_all("idle");
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        send_str("xo_ox_x_o");
        chk("frame1.marked", grid_state_marked, 9'b110110101);
        chk("frame1.x", grid_state_x, 9'b100010100);

        send(8'h0A);
        send(8'h0D);
        send_str("_________");
        chk("blank.marked", grid_state_marked, 9'd0);

        send_str("xoQ");
        send_str("abc");
        send(8'h0A);
        send_str("xxxxooooo");
`ifndef TTT_COUNT_CHECK_EN
        chk("full.marked", grid_state_marked, 9'h1FF);
        chk("full.x", grid_state_x, 9'h1E0);
`endif
        send(8'h0A);
        send(8'h0A);

        send_str("xox");
        send(8'h0A);
        send(8'h78);
        send(8'h0A);
        idle(2);

        send_str("xoxox");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset.marked", grid_state_marked, 9'd0);
        chk("async_reset.x", grid_state_x, 9'd0);
        chk("async_reset.cell_count", 9'(cell_count), 9'd0);
        chk("async_reset.in_ready", 9'(in_ready), 9'd1);
        @(negedge clk);
        reset = 1'b0;
        send_str("o_x_o_x_x");
        chk("post_reset.marked", grid_state_marked, 9'b101010101);

        send_str("xxx______");
`ifndef TTT_COUNT_CHECK_EN
        chk("xxx.x", grid_state_x, 9'b111000000);
`endif
        send(8'h0A);
        send(8'h0A);

        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) send(8'h0A);
            for (int c = 0; c < 9; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    send(8'($urandom_range(0, 255)));
                    send(8'h0A);
                    send(8'h0A);
                    break;
                end
                case ($urandom_range(0, 2))
                    0:       send(8'h78);
                    1:       send(8'h6F);
                    default: send(8'h5F);
                endcase
            end
            if (merr || mq.size() != 0) begin
                send(8'h0A);
                send(8'h0A);
            end
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
